multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the 32-bit MIPS-subset datapath (PC, IR, register file, ALU, shared memory bus). It replaces single-cycle combinational decode with a state machine. Each instruction is stepped through fetch, decode, execute, memory and write-back phases over one shared memory port, with a ready handshake on that port. It also counts retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: steps each instruction
// through fetch/decode/execute/memory/write-back over one shared memory port.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        ir_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_wrt,
  output logic        mem_reg,
  output logic        reg_dst,
  output logic        reg_wrt,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_WB_MEM = 4'd5,
    S_MEM_WR = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_ALU = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;
  logic        mem_phase, timeout, retire;

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout   = mem_phase && !mem_ready && (wait_q == WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 6'd0;
      wait_q    <= 8'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire   = 1'b0;
    pc_en    = 1'b0;
    pc_src   = 2'b00;
    ir_en    = 1'b0;
    iord     = 1'b0;
    mem_read = 1'b0;
    mem_wrt  = 1'b0;
    mem_reg  = 1'b0;
    reg_dst  = 1'b0;
    reg_wrt  = 1'b0;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_ADDR: begin
        alu_src = 1'b1;
        state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        alu_src  = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_wrt = 1'b1;
        mem_reg = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        mem_wrt = 1'b1;
        iord    = 1'b1;
        alu_src = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_op  = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src = 1'b1;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_wrt = 1'b1;
        reg_dst = (op_q == OP_RTYPE);
        // Hold the ALU setup of the EXEC state so the result stays stable during write-back
        if (op_q == OP_RTYPE) alu_op = 2'b10;
        else                  alu_src = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_op  = 2'b01;
        pc_src  = 2'b01;
        pc_en   = zero;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        pc_en   = 1'b1;
        pc_src  = 2'b10;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout abandons the instruction; mem_ready in the same cycle wins because timeout needs it low
    if (timeout) begin
      bus_err = 1'b1;
      state_d = S_FETCH;
    end
  end

  assign wait_d    = (mem_phase && !mem_ready && !timeout) ? wait_q + 8'd1 : 8'd0;
  assign retired_d = retire ? retired_q + 32'd1 : retired_q;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed traces with literal expectations,
// then randomized stimulus checked every cycle against a route-based instruction model.
module tb_multicycle_ctrl;

  localparam int LIMIT = 4;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_en, ir_en, iord, mem_read, mem_wrt, mem_reg, reg_dst, reg_wrt, alu_src;
  logic illegal, bus_err;
  logic [1:0] pc_src, alu_op;
  logic [3:0] state;
  logic [31:0] retired;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic       pcEn;
    logic [1:0] pcSrc;
    logic       irEn;
    logic       iorD;
    logic       memRead;
    logic       memWrt;
    logic       memReg;
    logic       regDst;
    logic       regWrt;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       illegalP;
    logic       busErr;
  } ctrl_t;

  ctrl_t dutCtrl;
  assign dutCtrl = {pc_en, pc_src, ir_en, iord, mem_read, mem_wrt, mem_reg,
                    reg_dst, reg_wrt, alu_src, alu_op, illegal, bus_err};

  multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .ir_en(ir_en), .iord(iord),
    .mem_read(mem_read), .mem_wrt(mem_wrt), .mem_reg(mem_reg), .reg_dst(reg_dst),
    .reg_wrt(reg_wrt), .alu_src(alu_src), .alu_op(alu_op), .state(state),
    .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change just after the rising edge; checks happen on the following falling edge
  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
    @(posedge clk);
    #1;
    opcode = op;
    zero = z;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  // Model: an instruction is a route of states chosen at decode; memory states may stall
  int mState;
  int mWait;
  int route[$];
  logic [5:0] mOp;
  logic [31:0] mRetired;

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  function automatic ctrl_t expCtrl(input int s, input logic [5:0] op, input logic z,
                                    input logic rdy, input int w);
    ctrl_t c;
    c = '0;
    case (s)
      1: begin c.memRead = 1; c.irEn = rdy; c.pcEn = rdy; end
      2: c.illegalP = !isLegal(op);
      3: c.aluSrc = 1;
      4: begin c.memRead = 1; c.iorD = 1; c.aluSrc = 1; end
      5: begin c.regWrt = 1; c.memReg = 1; end
      6: begin c.memWrt = 1; c.iorD = 1; c.aluSrc = 1; end
      7: c.aluOp = 2'b10;
      8: c.aluSrc = 1;
      9: begin
        c.regWrt = 1;
        c.regDst = (op == OP_R);
        if (op == OP_R) c.aluOp = 2'b10;
        else c.aluSrc = 1;
      end
      10: begin c.aluOp = 2'b01; c.pcSrc = 2'b01; c.pcEn = z; end
      11: begin c.pcEn = 1; c.pcSrc = 2'b10; end
      default: c = '0;
    endcase
    c.busErr = (s == 1 || s == 4 || s == 6) && !rdy && (w == LIMIT);
    return c;
  endfunction

  task automatic modelReset();
    mState = 0;
    mWait = 0;
    mOp = 6'd0;
    mRetired = 32'd0;
    route.delete();
  endtask

  task automatic modelStep();
    bit memPhase;
    memPhase = (mState == 1 || mState == 4 || mState == 6);
    if (memPhase && !mem_ready) begin
      if (mWait == LIMIT) begin
        route.delete();
        mState = 1;
        mWait = 0;
      end else begin
        mWait++;
      end
    end else begin
      mWait = 0;
      case (mState)
        0: mState = 1;
        1: mState = 2;
        2: begin
          mOp = opcode;
          case (opcode)
            OP_R:    route = '{7, 9};
            OP_LW:   route = '{3, 4, 5};
            OP_SW:   route = '{3, 6};
            OP_BEQ:  route = '{10};
            OP_ADDI: route = '{8, 9};
            OP_J:    route = '{11};
            default: route.delete();
          endcase
          mState = (route.size() == 0) ? 1 : route.pop_front();
        end
        default: begin
          if (route.size() == 0) begin
            mRetired = mRetired + 32'd1;
            mState = 1;
          end else begin
            mState = route.pop_front();
          end
        end
      endcase
    end
  endtask

  // Every falling edge: compare the DUT against the model, then advance the model
  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        modelReset();
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_ctrl", 32'(dutCtrl), 32'd0);
        checkOutput("reset_retired", retired, 32'd0);
      end else begin
        checkOutput("model_state", 32'(state), 32'(mState));
        checkOutput("model_ctrl", 32'(dutCtrl),
                    32'(expCtrl(mState, (mState == 2) ? opcode : mOp, zero, mem_ready, mWait)));
        checkOutput("model_retired", retired, mRetired);
        modelStep();
      end
    end
  end

  initial begin
    logic [5:0] legalOps [6];
    logic [5:0] op;
    int stall;
    legalOps = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    stall = 0;

    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("por_state", 32'(state), 32'd0);
    checkOutput("por_retired", retired, 32'd0);

    // R-type with no waits: 0,1,2,7,9,1
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("r_idle", 32'(state), 32'd0);
    applyStimulus(OP_R, 0, 1);
    checkOutput("r_fetch", 32'(state), 32'd1);
    checkOutput("r_fetch_ir_en", 32'(ir_en), 32'd1);
    applyStimulus(OP_R, 0, 1);
    checkOutput("r_decode", 32'(state), 32'd2);
    applyStimulus(OP_R, 0, 1);
    checkOutput("r_exec", 32'(state), 32'd7);
    applyStimulus(OP_R, 0, 1);
    checkOutput("r_wb", 32'(state), 32'd9);
    checkOutput("r_wb_regwrt", 32'(reg_wrt), 32'd1);
    checkOutput("r_wb_regdst", 32'(reg_dst), 32'd1);
    applyStimulus(OP_LW, 0, 1);
    checkOutput("r_back_fetch", 32'(state), 32'd1);
    checkOutput("r_retired", retired, 32'd1);

    // lw with three wait cycles in MEM_RD; FETCH to FETCH in 8 cycles
    applyStimulus(OP_LW, 0, 1);
    checkOutput("lw_decode", 32'(state), 32'd2);
    applyStimulus(OP_LW, 0, 0);
    checkOutput("lw_addr", 32'(state), 32'd3);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(OP_LW, 0, (k == 3));
      checkOutput("lw_memrd_state", 32'(state), 32'd4);
      checkOutput("lw_memrd_strobe", 32'({mem_read, iord}), 32'd3);
    end
    applyStimulus(OP_BEQ, 1, 1);
    checkOutput("lw_wb_state", 32'(state), 32'd5);
    checkOutput("lw_wb_ctrl", 32'({mem_reg, reg_wrt}), 32'd3);
    applyStimulus(OP_BEQ, 1, 1);
    checkOutput("lw_fetch_8cyc", 32'(state), 32'd1);
    checkOutput("lw_retired", retired, 32'd2);

    // beq taken then not taken
    applyStimulus(OP_BEQ, 1, 1);
    applyStimulus(OP_BEQ, 1, 1);
    checkOutput("beq1_state", 32'(state), 32'd10);
    checkOutput("beq1_pc", 32'({pc_en, pc_src}), 32'b101);
    applyStimulus(OP_BEQ, 0, 1);
    applyStimulus(OP_BEQ, 0, 1);
    applyStimulus(OP_BEQ, 0, 1);
    checkOutput("beq0_state", 32'(state), 32'd10);
    checkOutput("beq0_pc_en", 32'(pc_en), 32'd0);
    applyStimulus(6'h3f, 0, 1);
    checkOutput("beq_retired", retired, 32'd4);

    // Illegal opcode pulses in DECODE and returns to FETCH
    applyStimulus(6'h3f, 0, 1);
    checkOutput("ill_decode", 32'({state, illegal}), 32'h5);
    applyStimulus(OP_SW, 0, 1);
    checkOutput("ill_fetch", 32'({state, illegal}), 32'h2);
    checkOutput("ill_retired", retired, 32'd4);

    // sw timeout: bus_err on the 5th MEM_WR cycle
    applyStimulus(OP_SW, 0, 1);
    applyStimulus(OP_SW, 0, 0);
    checkOutput("sw_addr", 32'(state), 32'd3);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(OP_SW, 0, 0);
      checkOutput("sw_memwr_state", 32'(state), 32'd6);
      checkOutput("sw_bus_err", 32'(bus_err), 32'(k == 5));
    end
    applyStimulus(OP_LW, 0, 1);
    checkOutput("sw_tmo_fetch", 32'({state, bus_err}), 32'h2);
    checkOutput("sw_tmo_retired", retired, 32'd4);

    // Asynchronous reset in the middle of MEM_RD
    applyStimulus(OP_LW, 0, 1);
    applyStimulus(OP_LW, 0, 0);
    applyStimulus(OP_LW, 0, 0);
    checkOutput("arst_pre_memread", 32'({state, mem_read}), 32'h9);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_state", 32'(state), 32'd0);
    checkOutput("arst_memread", 32'(mem_read), 32'd0);
    checkOutput("arst_retired", retired, 32'd0);
    repeat (2) applyStimulus(OP_R, 0, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized run with bursts of stalls long enough to time out
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) < 7) op = legalOps[$urandom_range(0, 5)];
      else op = 6'($urandom_range(0, 63));
      if (stall > 0) stall--;
      else if ($urandom_range(0, 24) == 0) stall = $urandom_range(1, 8);
      applyStimulus(op, 1'($urandom_range(0, 1)), (stall == 0) && ($urandom_range(0, 3) != 0));
      if (i == 2000) begin
        rst_n = 1'b0;
        repeat (2) applyStimulus(OP_R, 0, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
